// File: rtl/fileio_ctrl_pkg.sv
// Shared constants for the file I/O offload controller: CPU register map, status/control
// bit positions, master FSM encoding and the file I/O peripheral register offsets.
package fileio_ctrl_pkg;

    localparam logic [2:0] OffCtrl   = 3'h0;
    localparam logic [2:0] OffStat   = 3'h2;
    localparam logic [2:0] OffRxdata = 3'h4;
    localparam logic [2:0] OffTxdata = 3'h6;

    localparam int unsigned CtrlEn   = 0;
    localparam int unsigned CtrlRxIe = 1;
    localparam int unsigned CtrlTxIe = 2;

    localparam int unsigned StatRxAvail = 0;
    localparam int unsigned StatTxFull  = 1;
    localparam int unsigned StatTxEmpty = 2;
    localparam int unsigned StatTxOvf   = 3;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StTxWr   = 2'd1;
    localparam logic [1:0] StRxPoll = 2'd2;
    localparam logic [1:0] StRxRead = 2'd3;

    localparam logic [14:0] FioStatusOff = 15'h0000;
    localparam logic [14:0] FioDataOff   = 15'h0002;

endpackage

// File: rtl/fileio_fifo.sv
// Byte FIFO with 2^FIFO_AW entries; a push while full is accepted when a pop lands on
// the same edge.
module fileio_fifo #(
    parameter int unsigned FIFO_AW = 2
) (
    input  logic       mclk,
    input  logic       puc_rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       empty,
    output logic       full
);
    localparam int unsigned Depth = 1 << FIFO_AW;

    logic [7:0]         mem_q [Depth];
    logic [FIFO_AW-1:0] wptr_q;
    logic [FIFO_AW-1:0] rptr_q;
    logic [FIFO_AW:0]   count_q;
    logic               do_push;
    logic               do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (FIFO_AW + 1)'(Depth));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem_q[rptr_q];

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + FIFO_AW'(1);
            if (do_pop)  rptr_q <= rptr_q + FIFO_AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (FIFO_AW + 1)'(1);
                2'b01:   count_q <= count_q - (FIFO_AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge mclk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/fileio_ctrl.sv
// File I/O offload controller: CPU-facing FIFO register block plus a private bus master
// that drains TX bytes into, and pulls RX bytes out of, the file I/O peripheral.
module fileio_ctrl
    import fileio_ctrl_pkg::*;
#(
    parameter logic [14:0] BASE_ADDR = 15'h0180,
    parameter int unsigned DEC_WD    = 3,
    parameter logic [14:0] FIO_BASE  = 15'h00c0,
    parameter int unsigned FIFO_AW   = 2
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    output logic [13:0] fio_addr,
    output logic [15:0] fio_din,
    output logic        fio_en,
    output logic [1:0]  fio_we,
    input  logic [15:0] fio_dout,
    output logic        irq
);
    localparam logic [13:0] FioStatusAddr = 14'((FIO_BASE + FioStatusOff) >> 1);
    localparam logic [13:0] FioDataAddr   = 14'((FIO_BASE + FioDataOff) >> 1);

    logic              reg_sel, reg_rd, reg_wr;
    logic [DEC_WD-1:0] reg_off;
    logic              ctrl_wr, stat_wr, txdata_wr, rxdata_rd;
    logic [2:0]        ctrl_q;
    logic              tx_ovf_q;
    logic [1:0]        state_q, state_d;
    logic              last_tx_q, last_tx_d;
    logic              tx_pop, tx_empty, tx_full;
    logic              rx_push, rx_empty, rx_full;
    logic [7:0]        tx_rdata, rx_rdata;
    logic [15:0]       stat;
    logic              unused_bits;

    assign unused_bits = ^{per_din[15:8], fio_dout[15:8]};

    assign reg_sel   = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
    assign reg_off   = {per_addr[DEC_WD-2:0], 1'b0};
    assign reg_rd    = reg_sel & (per_we == 2'b00);
    assign reg_wr    = reg_sel & per_we[0];
    assign ctrl_wr   = reg_wr & (reg_off == DEC_WD'(OffCtrl));
    assign stat_wr   = reg_wr & (reg_off == DEC_WD'(OffStat));
    assign txdata_wr = reg_wr & (reg_off == DEC_WD'(OffTxdata));
    assign rxdata_rd = reg_rd & (reg_off == DEC_WD'(OffRxdata));

    assign tx_pop  = (state_q == StTxWr);
    assign rx_push = (state_q == StRxRead);

    fileio_fifo #(.FIFO_AW(FIFO_AW)) u_tx_fifo (
        .mclk    (mclk),
        .puc_rst (puc_rst),
        .push    (txdata_wr),
        .pop     (tx_pop),
        .wdata   (per_din[7:0]),
        .rdata   (tx_rdata),
        .empty   (tx_empty),
        .full    (tx_full)
    );

    fileio_fifo #(.FIFO_AW(FIFO_AW)) u_rx_fifo (
        .mclk    (mclk),
        .puc_rst (puc_rst),
        .push    (rx_push),
        .pop     (rxdata_rd),
        .wdata   (fio_dout[7:0]),
        .rdata   (rx_rdata),
        .empty   (rx_empty),
        .full    (rx_full)
    );

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            ctrl_q   <= 3'b000;
            tx_ovf_q <= 1'b0;
        end else begin
            if (ctrl_wr) ctrl_q <= per_din[2:0];
            // A byte is only lost when no drain frees a slot on the same edge.
            if (stat_wr && per_din[StatTxOvf]) begin
                tx_ovf_q <= 1'b0;
            end else if (txdata_wr && tx_full && !tx_pop) begin
                tx_ovf_q <= 1'b1;
            end
        end
    end

    assign stat = {12'h000, tx_ovf_q, tx_empty, tx_full, ~rx_empty};

    always_comb begin
        per_dout = 16'h0000;
        if (reg_rd) begin
            case (reg_off)
                DEC_WD'(OffCtrl):   per_dout = {13'h0000, ctrl_q};
                DEC_WD'(OffStat):   per_dout = stat;
                DEC_WD'(OffRxdata): per_dout = rx_empty ? 16'h0000 : {8'h00, rx_rdata};
                default:            per_dout = 16'h0000;
            endcase
        end
    end

    assign irq = (ctrl_q[CtrlRxIe] & ~rx_empty) | (ctrl_q[CtrlTxIe] & tx_empty);

    always_comb begin
        state_d   = state_q;
        last_tx_d = last_tx_q;
        case (state_q)
            StIdle: begin
                if (ctrl_q[CtrlEn]) begin
                    // Round-robin: TX wins unless RX is also possible and TX went last.
                    if (!tx_empty && (rx_full || !last_tx_q)) begin
                        state_d   = StTxWr;
                        last_tx_d = 1'b1;
                    end else if (!rx_full) begin
                        state_d   = StRxPoll;
                        last_tx_d = 1'b0;
                    end
                end
            end
            StTxWr:   state_d = StIdle;
            StRxPoll: state_d = fio_dout[0] ? StRxRead : StIdle;
            StRxRead: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q   <= StIdle;
            last_tx_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_tx_q <= last_tx_d;
        end
    end

    always_comb begin
        fio_en   = 1'b0;
        fio_we   = 2'b00;
        fio_addr = 14'h0000;
        fio_din  = 16'h0000;
        case (state_q)
            StTxWr: begin
                fio_en   = 1'b1;
                fio_we   = 2'b01;
                fio_addr = FioDataAddr;
                fio_din  = {8'h00, tx_rdata};
            end
            StRxPoll: begin
                fio_en   = 1'b1;
                fio_addr = FioStatusAddr;
            end
            StRxRead: begin
                fio_en   = 1'b1;
                fio_addr = FioDataAddr;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fileio_ctrl.sv
// Scoreboard bench for fileio_ctrl: a queue-based model of both FIFOs, the CPU registers
// and a file I/O peripheral, with directed scenarios followed by random traffic.
module tb_fileio_ctrl;

    localparam logic [13:0] ACtrl   = 14'h00c0;
    localparam logic [13:0] AStat   = 14'h00c1;
    localparam logic [13:0] ARx     = 14'h00c2;
    localparam logic [13:0] ATx     = 14'h00c3;
    localparam logic [13:0] FioStat = 14'h0060;
    localparam logic [13:0] FioData = 14'h0061;

    logic        mclk = 1'b0;
    logic        puc_rst = 1'b1;
    logic [13:0] per_addr = '0;
    logic [15:0] per_din = '0;
    logic        per_en = 1'b0;
    logic [1:0]  per_we = 2'b00;
    logic [15:0] per_dout;
    logic [13:0] fio_addr;
    logic [15:0] fio_din;
    logic        fio_en;
    logic [1:0]  fio_we;
    logic [15:0] fio_dout;
    logic        irq;

    fileio_ctrl dut (
        .mclk     (mclk),
        .puc_rst  (puc_rst),
        .per_addr (per_addr),
        .per_din  (per_din),
        .per_en   (per_en),
        .per_we   (per_we),
        .per_dout (per_dout),
        .fio_addr (fio_addr),
        .fio_din  (fio_din),
        .fio_en   (fio_en),
        .fio_we   (fio_we),
        .fio_dout (fio_dout),
        .irq      (irq)
    );

    always #5 mclk = ~mclk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [7:0]  exp_tx[$];
    logic [7:0]  rxq[$];
    logic [15:0] exp_rd[$];
    int          job_log[$];
    logic        log_on = 1'b0;
    logic [2:0]  m_ctrl = 3'b000;
    logic        m_ovf = 1'b0;
    logic        want_job_q = 1'b0;
    logic        en_q = 1'b0;

    // File I/O peripheral model: a byte stream offered through STATUS/DATA
    logic [7:0] in_mem [0:1023];
    int         in_wr = 0;
    int         in_rd = 0;

    always_comb begin
        fio_dout = 16'h0000;
        if (fio_addr == FioStat) fio_dout = {15'h0000, (in_rd < in_wr)};
        else if (fio_addr == FioData) fio_dout = {8'h00, in_mem[in_rd[9:0]]};
    end

    always @(posedge mclk) begin
        if (!puc_rst && fio_en && fio_we == 2'b00 && fio_addr == FioData && in_rd < in_wr)
            in_rd <= in_rd + 1;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_line(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got unexpected event expected none at %0t", name, $time);
    endtask

    task automatic model_clear();
        exp_tx.delete();
        rxq.delete();
        exp_rd.delete();
        m_ctrl = 3'b000;
        m_ovf  = 1'b0;
    endtask

    function automatic logic [15:0] exp_read(input logic [13:0] a);
        case (a)
            ACtrl:   return {13'h0000, m_ctrl};
            AStat:   return {12'h000, m_ovf, (exp_tx.size() == 0), (exp_tx.size() == 4),
                             (rxq.size() != 0)};
            ARx:     return (rxq.size() != 0) ? {8'h00, rxq[0]} : 16'h0000;
            default: return 16'h0000;
        endcase
    endfunction

    // Monitor: mid-cycle, compare against pre-edge model state, then apply the edge.
    always @(negedge mclk) begin
        int          tx_n;
        logic        drain, poll, rd, start, exp_irq;
        if (puc_rst) begin
            want_job_q = 1'b0;
            en_q       = 1'b0;
        end else begin
            tx_n    = exp_tx.size();
            drain   = fio_en && fio_we == 2'b01 && fio_addr == FioData;
            poll    = fio_en && fio_we == 2'b00 && fio_addr == FioStat;
            rd      = fio_en && fio_we == 2'b00 && fio_addr == FioData;
            start   = drain || poll;
            exp_irq = (m_ctrl[1] && rxq.size() != 0) || (m_ctrl[2] && tx_n == 0);
            check("irq", 16'(irq), 16'(exp_irq));
            if (fio_en && !(drain || poll || rd)) fail_line("fio_bus_pattern");
            if (want_job_q) check("job_start", 16'(start), 16'h0001);
            if (start) check("job_enabled", 16'(en_q), 16'h0001);
            want_job_q = m_ctrl[0] && !fio_en && (tx_n != 0 || rxq.size() < 4);
            en_q       = m_ctrl[0];

            if (per_en && per_we == 2'b00) begin
                if (exp_rd.size() == 0) fail_line("per_read_unexpected");
                else check("per_dout", per_dout, exp_rd.pop_front());
                if (per_addr == ARx && rxq.size() != 0) void'(rxq.pop_front());
            end else begin
                check("per_dout_idle", per_dout, 16'h0000);
                if (per_en && per_we[0]) begin
                    if (per_addr == ACtrl) begin
                        m_ctrl = per_din[2:0];
                    end else if (per_addr == AStat) begin
                        if (per_din[3]) m_ovf = 1'b0;
                    end else if (per_addr == ATx) begin
                        if (tx_n < 4 || drain) exp_tx.push_back(per_din[7:0]);
                        else m_ovf = 1'b1;
                    end
                end
            end

            if (drain) begin
                if (tx_n == 0) fail_line("tx_write_while_empty");
                else check("tx_byte", fio_din, {8'h00, exp_tx.pop_front()});
            end
            if (rd) begin
                if (in_rd >= in_wr || rxq.size() >= 4) fail_line("rx_read_invalid");
                else rxq.push_back(in_mem[in_rd[9:0]]);
            end
            if (log_on && start) job_log.push_back(drain ? 1 : 2);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic cpu_op(input logic [13:0] a, input logic [15:0] d, input logic [1:0] we);
        per_addr = a;
        per_din  = d;
        per_we   = we;
        per_en   = 1'b1;
        if (we == 2'b00) exp_rd.push_back(exp_read(a));
        @(posedge mclk);
        #1;
        per_en = 1'b0;
        per_we = 2'b00;
    endtask

    task automatic offer(input logic [7:0] b);
        in_mem[in_wr[9:0]] = b;
        in_wr = in_wr + 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          r;
        logic [15:0] d;
        model_clear();
        #1;
        check("rst_irq", 16'(irq), 16'h0000);
        check("rst_fio_en", 16'(fio_en), 16'h0000);
        check("rst_fio_we", 16'(fio_we), 16'h0000);
        check("rst_fio_addr", 16'(fio_addr), 16'h0000);
        check("rst_fio_din", fio_din, 16'h0000);
        check("rst_per_dout", per_dout, 16'h0000);
        idle(2);
        puc_rst = 1'b0;
        idle(1);
        cpu_op(AStat, 16'h0000, 2'b00);

        // Enable and send two bytes
        cpu_op(ACtrl, 16'h0001, 2'b01);
        cpu_op(ATx, 16'h0041, 2'b01);
        cpu_op(ATx, 16'h0042, 2'b01);
        idle(6);
        cpu_op(AStat, 16'h0000, 2'b00);

        // Overflow with the master disabled, then clear the sticky flag
        cpu_op(ACtrl, 16'h0000, 2'b01);
        idle(2);
        for (int i = 0; i < 5; i++) cpu_op(ATx, 16'(8'h10 + i), 2'b01);
        cpu_op(AStat, 16'h0000, 2'b00);
        cpu_op(AStat, 16'h0008, 2'b11);
        cpu_op(AStat, 16'h0000, 2'b00);
        cpu_op(ATx, 16'h0077, 2'b10);
        cpu_op(AStat, 16'h0000, 2'b00);

        // Drain, then receive "AB"
        cpu_op(ACtrl, 16'h0001, 2'b01);
        idle(12);
        offer(8'h41);
        offer(8'h42);
        idle(12);
        cpu_op(AStat, 16'h0000, 2'b00);
        cpu_op(ARx, 16'h0000, 2'b00);
        cpu_op(ARx, 16'h0000, 2'b00);
        cpu_op(ARx, 16'h0000, 2'b00);

        // RX interrupt
        cpu_op(ACtrl, 16'h0003, 2'b01);
        offer(8'h55);
        for (int i = 0; i < 20 && !irq; i++) idle(1);
        check("irq_rx_rise", 16'(irq), 16'h0001);
        cpu_op(ARx, 16'h0000, 2'b00);
        check("irq_after_pop", 16'(irq), 16'h0000);
        cpu_op(ACtrl, 16'h0005, 2'b01);
        idle(2);
        cpu_op(ACtrl, 16'h0000, 2'b01);
        idle(3);

        // Round-robin with both jobs pending
        for (int i = 0; i < 3; i++) cpu_op(ATx, 16'(8'ha0 + i), 2'b01);
        for (int i = 0; i < 3; i++) offer(8'(8'hc0 + i));
        job_log.delete();
        log_on = 1'b1;
        cpu_op(ACtrl, 16'h0001, 2'b01);
        idle(20);
        log_on = 1'b0;
        if (job_log.size() < 4) begin
            fail_line("rr_too_few_jobs");
        end else begin
            for (int i = 1; i < 4; i++) check("rr_alternate", 16'(job_log[i] != job_log[i-1]),
                                              16'h0001);
        end

        // Reset in the middle of an RX_READ
        offer(8'h99);
        for (int i = 0; i < 40 && !(fio_en && fio_we == 2'b00 && fio_addr == FioData); i++)
            idle(1);
        if (!(fio_en && fio_we == 2'b00 && fio_addr == FioData)) begin
            fail_line("rx_read_not_seen");
        end
        puc_rst = 1'b1;
        #1;
        check("rst_abort_fio_en", 16'(fio_en), 16'h0000);
        model_clear();
        idle(1);
        puc_rst = 1'b0;
        in_wr = in_rd;
        idle(1);
        cpu_op(AStat, 16'h0000, 2'b00);
        cpu_op(ARx, 16'h0000, 2'b00);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 9);
            d = 16'($urandom);
            case (r)
                0, 1, 2: cpu_op(ATx, d, ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b01);
                3, 4:    cpu_op(ARx, d, 2'b00);
                5:       cpu_op(AStat, d, 2'b00);
                6: begin
                    d[0] = ($urandom_range(0, 3) != 0);
                    cpu_op(ACtrl, d, ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b01);
                end
                7: begin
                    if (in_wr < 1000) offer(8'($urandom));
                    idle(1);
                end
                8:       cpu_op(AStat, d, 2'b01);
                default: cpu_op(($urandom_range(0, 1) == 0) ? ACtrl : 14'h00c4, d, 2'b00);
            endcase
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
